mmul_job_scheduler: RTL and testbench
=====================================

# mmul_job_scheduler

Sequencer and arbiter for the systolic matrix-multiply datapath. It accepts job requests from `NUM_REQ` requesters, grants the datapath to one at a time in round-robin order, and pulses the datapath controller's start. It waits out the fill/skew/compute window, snapshots the result array, and writes it row-major into a shared result RAM region owned by the granted requester. It sits between the requester ports and the existing controller/ROM/shift-register/systolic-array datapath.

## Interface
Parameters:
- `DATA_WIDTH`, 8, operand width; results are `2*DATA_WIDTH`.
- `A_ROWS`, 2, rows of A and C.
- `A_COLS`, 2, cols of A / rows of B.
- `B_COLS`, 2, cols of B and C.
- `NUM_REQ`, 2, number of requesters (≥1).

Ports:
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  reset, asynchronous, active-high.
- `req`  in  `NUM_REQ`  level job request, one bit per requester.
- `grant`  out  `NUM_REQ`  one-hot owner of the datapath; all-zero when idle.
- `done`  out  `NUM_REQ`  one-cycle completion pulse to the owner.
- `busy`  out  1  high in every state except IDLE.
- `ctrl_start`  out  1  one-cycle start pulse to the datapath controller.
- `array_clear`  out  1  one-cycle accumulator clear to the systolic array.
- `result_flat`  in  `A_ROWS*B_COLS*2*DATA_WIDTH`  array outputs; element (i,j) at slice `(i*B_COLS+j)*2*DATA_WIDTH +: 2*DATA_WIDTH`.
- `wr_en`  out  1  result RAM write strobe.
- `wr_addr`  out  `$clog2(NUM_REQ*ELEMS)`  result RAM address.
- `wr_data`  out  `2*DATA_WIDTH`  result element.

## Operation
- `ELEMS = A_ROWS*B_COLS`. `RUN_CYCLES = A_ROWS+A_COLS+B_COLS` (6 with defaults).
- FSM states are IDLE, START, RUN, DRAIN, DONE.
- IDLE: if any `req` is set, select the owner round-robin from pointer `ptr`. Register a one-hot `grant`, set `ctrl_start=1`, set `ptr=(owner+1) mod NUM_REQ`, and go to START.
- START: lasts one cycle. Go to RUN with `run_cnt=0`.
- RUN: increment `run_cnt`. When `run_cnt==RUN_CYCLES-1`, capture `result_flat` into the internal snapshot buffer, pulse `array_clear`, set `elem_cnt=0`, and go to DRAIN.
- DRAIN: assert `wr_en` each cycle with `wr_addr=owner*ELEMS+elem_cnt` and `wr_data=snapshot[elem_cnt]`. After `elem_cnt==ELEMS-1`, go to DONE.
- DONE: pulse `done[owner]` for one cycle with `grant` still held, then go to IDLE and clear `grant`.
- `req` is sampled only in IDLE. Deasserting `req` mid-job does not abort; the job completes.
- A requester that still holds `req` in the cycle after DONE is re-served, subject to round-robin order.
- Simultaneous requests: the first set bit at or after `ptr` wins.
- `NUM_REQ=1`: the owner is always 0 and `ptr` stays 0.
- All outputs are registered. Address arithmetic is unsigned, and no wrap is possible by construction.

## Timing
- Reset (asynchronous, any state including mid-DRAIN):
  - state returns to IDLE; `ptr=0`, `run_cnt=0`, `elem_cnt=0`, snapshot buffer zeroed.
  - `grant`, `done`, `busy`, `ctrl_start`, `array_clear`, `wr_en`, `wr_addr`, `wr_data` all go to 0.
  - A partial drain is abandoned with no further writes.
- With `req` first sampled at edge 0, the defaults give:
  - `grant`, `busy`, `ctrl_start`: edge 0.
  - RUN: edges 1..6.
  - `array_clear` and snapshot capture: edge 6.
  - `wr_en`: edges 7..10.
  - `done`: edge 11.
  - `grant` and `busy` fall: edge 12.
- General formula: `done` rises `1+RUN_CYCLES+ELEMS` edges after `grant` rises.
- Minimum gap between successive jobs is one IDLE cycle.

## Structure
- Package `mmul_pkg` holds:
  - the state enum `sched_state_t` (IDLE, START, RUN, DRAIN, DONE);
  - `localparam` helpers for `ELEMS`, `RUN_CYCLES` and the address width;
  - the result element type `logic [2*DATA_WIDTH-1:0]`.
- Sub-module `rr_arbiter`: parameterised by `NUM_REQ`. Inputs are `req` and `ptr`; outputs are a one-hot `gnt` and the owner index. It is purely combinational; `ptr` is registered in the scheduler.

## Test plan
- **Single job:** after reset, `req=01`; the bench drives `result_flat` = C of A=[[1,2],[3,4]] × B=[[5,6],[7,8]] → `ctrl_start` at edge 0, writes 19,22,43,50 to addr 0..3 at edges 7..10, `done=01` at edge 11.
- **Round-robin:** `req=11` held continuously → grant order 01, 10, 01. The second job writes addr 4..7.
- **Reset mid-DRAIN:** assert `reset` after 2 writes → all outputs 0 immediately, no further `wr_en`. After release, `req=10` is granted first and only if `req[0]=0`, since `ptr=0`.
- **Req drop:** `req` deasserted at edge 3 → the job still completes, with 4 writes and `done` at edge 11.
- **Busy blocking:** `req[1]` rises during RUN of job 0 → `grant=10` appears only at the edge after job 0's DONE+IDLE cycle.
- **Clear pulse:** `array_clear` is high exactly one cycle, coincident with snapshot capture. Changing `result_flat` during DRAIN does not alter `wr_data`.

Source files
------------

// File: rtl/mmul_job_scheduler_pkg.sv
// mmul_pkg: shared types and sizing helpers for the matrix-multiply job
// scheduler.
//   sched_state_t     - scheduler FSM state encoding
//   calc_elems        - number of result elements (A_ROWS*B_COLS)
//   calc_run_cycles   - fill/skew/compute window length
//   calc_idx_w        - index width for a count of n items (never below 1)
//   calc_addr_w       - result RAM address width for NUM_REQ regions
//   result_t          - result element type at the default operand width
package mmul_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        RUN   = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } sched_state_t;

    localparam int DATA_WIDTH_DEFAULT = 8;

    typedef logic [2*DATA_WIDTH_DEFAULT-1:0] result_t;

    function automatic int calc_elems(input int a_rows, input int b_cols);
        return a_rows * b_cols;
    endfunction

    function automatic int calc_run_cycles(input int a_rows, input int a_cols,
                                           input int b_cols);
        return a_rows + a_cols + b_cols;
    endfunction

    // A one-entry range still gets a 1-bit index so no zero-width vectors appear.
    function automatic int calc_idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic int calc_addr_w(input int num_req, input int elems);
        return calc_idx_w(num_req * elems);
    endfunction

endpackage

// File: rtl/mmul_job_scheduler_if.sv
// mmul_job_scheduler_if: bundle of requester, datapath-control and result-RAM
// signals of the job scheduler.
//   req          - level job request, one bit per requester
//   grant        - one-hot datapath owner, zero when idle
//   done         - one-cycle completion pulse to the owner
//   busy         - scheduler not idle
//   ctrl_start   - start pulse to the datapath controller
//   array_clear  - accumulator clear pulse to the systolic array
//   result_flat  - flattened systolic array results, element (i,j) at
//                  (i*B_COLS+j)*2*DATA_WIDTH
//   wr_en/wr_addr/wr_data - result RAM write port
// Modports: master = scheduler side, slave = requesters/datapath/RAM side.
//
// Request protocol: a requester raises req and holds it until it sees its
// grant bit; req is only looked at while the scheduler is idle, so dropping
// it after grant does not cancel the job. done[owner] pulses once with grant
// still held, and grant falls on the following cycle.
interface mmul_job_scheduler_if
    import mmul_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int A_ROWS     = 2,
    parameter int B_COLS     = 2,
    parameter int NUM_REQ    = 2
);
    localparam int ELEMS = calc_elems(A_ROWS, B_COLS);
    localparam int AW    = calc_addr_w(NUM_REQ, ELEMS);
    localparam int RW    = 2 * DATA_WIDTH;

    logic [NUM_REQ-1:0]  req;
    logic [NUM_REQ-1:0]  grant;
    logic [NUM_REQ-1:0]  done;
    logic                busy;
    logic                ctrl_start;
    logic                array_clear;
    logic [ELEMS*RW-1:0] result_flat;
    logic                wr_en;
    logic [AW-1:0]       wr_addr;
    logic [RW-1:0]       wr_data;

    modport master (
        input  req, result_flat,
        output grant, done, busy, ctrl_start, array_clear,
               wr_en, wr_addr, wr_data
    );

    modport slave (
        output req, result_flat,
        input  grant, done, busy, ctrl_start, array_clear,
               wr_en, wr_addr, wr_data
    );

endinterface

// File: rtl/mmul_job_scheduler_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick.
//   req - request vector
//   ptr - highest-priority index for this pick
//   gnt - one-hot winner (zero when no request)
//   idx - winner index (zero when no request)
// The first set request at or after ptr, wrapping around, wins.
module rr_arbiter
    import mmul_pkg::*;
#(
    parameter  int NUM_REQ = 2,
    localparam int IW      = calc_idx_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IW-1:0]      idx
);

    always_comb begin
        int   cand;
        logic found;
        gnt   = '0;
        idx   = '0;
        cand  = 0;
        found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = (int'(ptr) + i) % NUM_REQ;
            if (!found && req[IW'(cand)]) begin
                found            = 1'b1;
                gnt[IW'(cand)]   = 1'b1;
                idx              = IW'(cand);
            end
        end
    end

endmodule

// File: rtl/mmul_job_scheduler.sv
// mmul_job_scheduler: grants the systolic matrix-multiply datapath to one
// requester at a time (round-robin), pulses the controller start, waits out
// the fill/skew/compute window, snapshots the result array and writes it
// row-major into the owner's region of the shared result RAM.
//   clk       - rising-edge clock
//   reset     - asynchronous, active-high
//   bus       - requester/datapath/result RAM signals (master side)
//   dbg_state - current FSM state
// With defaults and req sampled at edge 0: grant/ctrl_start at edge 0,
// array_clear + snapshot at edge 6, writes at edges 7..10, done at edge 11,
// grant/busy fall at edge 12, and the next grant can come at edge 13.
module mmul_job_scheduler
    import mmul_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int A_ROWS     = 2,
    parameter int A_COLS     = 2,
    parameter int B_COLS     = 2,
    parameter int NUM_REQ    = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    mmul_job_scheduler_if.master  bus,
    output sched_state_t          dbg_state
);

    localparam int ELEMS      = calc_elems(A_ROWS, B_COLS);
    localparam int RUN_CYCLES = calc_run_cycles(A_ROWS, A_COLS, B_COLS);
    localparam int AW         = calc_addr_w(NUM_REQ, ELEMS);
    localparam int IW         = calc_idx_w(NUM_REQ);
    localparam int ECW        = calc_idx_w(ELEMS);
    localparam int RCW        = calc_idx_w(RUN_CYCLES);
    localparam int RW         = 2 * DATA_WIDTH;

    sched_state_t       state;
    logic [IW-1:0]      ptr;
    logic [IW-1:0]      owner;
    logic [RCW-1:0]     run_cnt;
    logic [ECW-1:0]     elem_cnt;
    logic [RW-1:0]      snap [ELEMS];

    logic [NUM_REQ-1:0] grant_r;
    logic [NUM_REQ-1:0] done_r;
    logic               busy_r;
    logic               ctrl_start_r;
    logic               array_clear_r;
    logic               wr_en_r;
    logic [AW-1:0]      wr_addr_r;
    logic [RW-1:0]      wr_data_r;

    logic [NUM_REQ-1:0] arb_gnt;
    logic [IW-1:0]      arb_idx;
    logic [IW-1:0]      next_ptr;
    logic [RCW-1:0]     run_cnt_nxt;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .req (bus.req),
        .ptr (ptr),
        .gnt (arb_gnt),
        .idx (arb_idx)
    );

    always_comb begin
        next_ptr    = IW'((int'(arb_idx) + 1) % NUM_REQ);
        run_cnt_nxt = run_cnt + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            ptr           <= '0;
            owner         <= '0;
            run_cnt       <= '0;
            elem_cnt      <= '0;
            for (int e = 0; e < ELEMS; e++) begin
                snap[e] <= '0;
            end
            grant_r       <= '0;
            done_r        <= '0;
            busy_r        <= 1'b0;
            ctrl_start_r  <= 1'b0;
            array_clear_r <= 1'b0;
            wr_en_r       <= 1'b0;
            wr_addr_r     <= '0;
            wr_data_r     <= '0;
        end else begin
            ctrl_start_r  <= 1'b0;
            array_clear_r <= 1'b0;
            case (state)
                IDLE: begin
                    grant_r <= '0;
                    done_r  <= '0;
                    busy_r  <= 1'b0;
                    wr_en_r <= 1'b0;
                    if (|bus.req) begin
                        grant_r      <= arb_gnt;
                        owner        <= arb_idx;
                        ptr          <= next_ptr;
                        ctrl_start_r <= 1'b1;
                        busy_r       <= 1'b1;
                        state        <= START;
                    end
                end
                START: begin
                    run_cnt <= '0;
                    state   <= RUN;
                end
                RUN: begin
                    run_cnt <= run_cnt_nxt;
                    // The window closes on the edge where the count reaches
                    // its last value, so results are grabbed on that edge.
                    if (run_cnt_nxt == RCW'(RUN_CYCLES - 1)) begin
                        for (int e = 0; e < ELEMS; e++) begin
                            snap[e] <= bus.result_flat[e*RW +: RW];
                        end
                        array_clear_r <= 1'b1;
                        elem_cnt      <= '0;
                        state         <= DRAIN;
                    end
                end
                DRAIN: begin
                    wr_en_r   <= 1'b1;
                    wr_addr_r <= AW'(int'(owner) * ELEMS + int'(elem_cnt));
                    wr_data_r <= snap[elem_cnt];
                    if (elem_cnt == ECW'(ELEMS - 1)) begin
                        state <= DONE;
                    end else begin
                        elem_cnt <= elem_cnt + 1'b1;
                    end
                end
                DONE: begin
                    wr_en_r <= 1'b0;
                    // First cycle raises done with grant held; the second
                    // drops everything so at least one idle cycle separates
                    // consecutive jobs.
                    if (|done_r) begin
                        done_r  <= '0;
                        grant_r <= '0;
                        busy_r  <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        done_r <= grant_r;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.grant       = grant_r;
    assign bus.done        = done_r;
    assign bus.busy        = busy_r;
    assign bus.ctrl_start  = ctrl_start_r;
    assign bus.array_clear = array_clear_r;
    assign bus.wr_en       = wr_en_r;
    assign bus.wr_addr     = wr_addr_r;
    assign bus.wr_data     = wr_data_r;
    assign dbg_state       = state;

endmodule

// File: tb/tb_mmul_job_scheduler.sv
module tb_mmul_job_scheduler;
  import mmul_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mmul_job_scheduler_if #(
    .DATA_WIDTH (8),
    .A_ROWS     (2),
    .B_COLS     (2),
    .NUM_REQ    (2)
  ) bus ();

  sched_state_t dut_state;

  mmul_job_scheduler #(
    .DATA_WIDTH (8),
    .A_ROWS     (2),
    .A_COLS     (2),
    .B_COLS     (2),
    .NUM_REQ    (2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus.master),
    .dbg_state (dut_state)
  );

  int n_cmp = 0;
  int n_err = 0;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".grant"}, 32'(bus.grant), 32'd0);
    check({tag, ".done"}, 32'(bus.done), 32'd0);
    check({tag, ".busy"}, 32'(bus.busy), 32'd0);
    check({tag, ".ctrl_start"}, 32'(bus.ctrl_start), 32'd0);
    check({tag, ".array_clear"}, 32'(bus.array_clear), 32'd0);
    check({tag, ".wr_en"}, 32'(bus.wr_en), 32'd0);
    check({tag, ".wr_addr"}, 32'(bus.wr_addr), 32'd0);
    check({tag, ".wr_data"}, 32'(bus.wr_data), 32'd0);
    check({tag, ".state"}, 32'(dut_state), 32'(IDLE));
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one full job from the sampling edge (edge 0) to grant release
  // (edge 12). req is changed to req_chg right after edge chg_edge (-1: never).
  task automatic run_job(input string name, input logic [1:0] exp_gnt, input int base,
                         input logic [15:0] e0, input logic [15:0] e1,
                         input logic [15:0] e2, input logic [15:0] e3,
                         input int chg_edge, input logic [1:0] req_chg);
    logic [15:0] ev [4];
    ev[0] = e0; ev[1] = e1; ev[2] = e2; ev[3] = e3;
    bus.result_flat = {e3, e2, e1, e0};
    tick();  // edge 0
    check({name, ".e0.grant"}, 32'(bus.grant), 32'(exp_gnt));
    check({name, ".e0.busy"}, 32'(bus.busy), 32'd1);
    check({name, ".e0.ctrl_start"}, 32'(bus.ctrl_start), 32'd1);
    check({name, ".e0.wr_en"}, 32'(bus.wr_en), 32'd0);
    if (chg_edge == 0) bus.req = req_chg;
    for (int k = 1; k <= 5; k++) begin
      tick();
      if (k == 1) check({name, ".e1.ctrl_start"}, 32'(bus.ctrl_start), 32'd0);
      check({name, ".run.array_clear"}, 32'(bus.array_clear), 32'd0);
      check({name, ".run.grant"}, 32'(bus.grant), 32'(exp_gnt));
      if (chg_edge == k) bus.req = req_chg;
    end
    tick();  // edge 6
    check({name, ".e6.array_clear"}, 32'(bus.array_clear), 32'd1);
    check({name, ".e6.wr_en"}, 32'(bus.wr_en), 32'd0);
    for (int e = 0; e < 4; e++) begin
      tick();  // edges 7..10
      if (e == 0) begin
        check({name, ".e7.array_clear"}, 32'(bus.array_clear), 32'd0);
        // Snapshot must already be frozen; disturb the live array outputs.
        bus.result_flat = ~bus.result_flat;
      end
      check({name, ".drain.wr_en"}, 32'(bus.wr_en), 32'd1);
      check({name, ".drain.wr_addr"}, 32'(bus.wr_addr), 32'(base + e));
      check({name, ".drain.wr_data"}, 32'(bus.wr_data), 32'(ev[e]));
      check({name, ".drain.done"}, 32'(bus.done), 32'd0);
    end
    tick();  // edge 11
    check({name, ".e11.done"}, 32'(bus.done), 32'(exp_gnt));
    check({name, ".e11.grant"}, 32'(bus.grant), 32'(exp_gnt));
    check({name, ".e11.wr_en"}, 32'(bus.wr_en), 32'd0);
    check({name, ".e11.busy"}, 32'(bus.busy), 32'd1);
    tick();  // edge 12
    check({name, ".e12.done"}, 32'(bus.done), 32'd0);
    check({name, ".e12.grant"}, 32'(bus.grant), 32'd0);
    check({name, ".e12.busy"}, 32'(bus.busy), 32'd0);
    check({name, ".e12.state"}, 32'(dut_state), 32'(IDLE));
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    bus.req = 2'b00;
    bus.result_flat = '0;

    // Reset state
    tick();
    tick();
    check_all_zero("reset");
    #3 reset = 1'b0;
    tick();
    check_all_zero("idle_after_reset");

    // Single job: C = [[1,2],[3,4]] x [[5,6],[7,8]] = [[19,22],[43,50]]
    bus.req = 2'b01;
    run_job("single", 2'b01, 0, 16'd19, 16'd22, 16'd43, 16'd50, 0, 2'b00);
    tick();
    check("single.gap.grant", 32'(bus.grant), 32'd0);

    // Reset mid-DRAIN: ptr is 1 now, so req=11 goes to requester 1.
    bus.req = 2'b11;
    bus.result_flat = {16'd4, 16'd3, 16'd2, 16'd1};
    tick();  // edge 0
    check("rst.grant", 32'(bus.grant), 32'd2);
    bus.req = 2'b00;
    for (int k = 1; k <= 8; k++) tick();
    check("rst.pre.wr_en", 32'(bus.wr_en), 32'd1);
    check("rst.pre.wr_addr", 32'(bus.wr_addr), 32'd5);
    check("rst.pre.wr_data", 32'(bus.wr_data), 32'd2);
    #2 reset = 1'b1;
    #1;
    check_all_zero("rst.async");
    tick();
    check("rst.held.wr_en", 32'(bus.wr_en), 32'd0);
    #3 reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("rst.after.wr_en", 32'(bus.wr_en), 32'd0);
      check("rst.after.grant", 32'(bus.grant), 32'd0);
    end

    // Round-robin with req=11 held: ptr is back to 0 -> 01, 10, 01.
    bus.req = 2'b11;
    run_job("rr1", 2'b01, 0, 16'd100, 16'd200, 16'd300, 16'd400, -1, 2'b11);
    run_job("rr2", 2'b10, 4, 16'h1234, 16'hABCD, 16'h0F0F, 16'hFFFF, -1, 2'b11);
    run_job("rr3", 2'b01, 0, 16'd7, 16'd8, 16'd9, 16'd10, 0, 2'b00);
    tick();
    check("rr.end.grant", 32'(bus.grant), 32'd0);

    // Req drop at edge 3: only requester 0 asks, job still completes.
    bus.req = 2'b01;
    run_job("drop", 2'b01, 0, 16'd11, 16'd12, 16'd13, 16'd14, 3, 2'b00);
    tick();
    check("drop.after.grant", 32'(bus.grant), 32'd0);

    // Busy blocking: req[1] rises during RUN of requester 0's job and is
    // served only after the idle cycle that follows it.
    bus.req = 2'b01;
    run_job("blk0", 2'b01, 0, 16'd21, 16'd22, 16'd23, 16'd24, 3, 2'b11);
    run_job("blk1", 2'b10, 4, 16'd31, 16'd32, 16'd33, 16'd34, 0, 2'b00);
    tick();
    check("blk.end.grant", 32'(bus.grant), 32'd0);
    check("blk.end.state", 32'(dut_state), 32'(IDLE));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
